// File: rtl/dsp_pkg.sv
// Shared DSP helpers: rounding and saturating requantisation used by the filter chain stages.
package dsp_pkg;

  // Requantised value carried at full integer width, plus a flag for a clamp.
  typedef struct packed {
    logic signed [31:0] val;
    logic               sat;
  } requant_t;

  // Largest value representable in a w_o-bit signed sample.
  function automatic int sat_max(input int unsigned w_o);
    return (32'sd1 <<< (w_o - 1)) - 32'sd1;
  endfunction

  // Smallest value representable in a w_o-bit signed sample.
  function automatic int sat_min(input int unsigned w_o);
    return -(32'sd1 <<< (w_o - 1));
  endfunction

  // Drop 'shift' fraction bits rounding half toward +inf, then clamp to w_o signed bits.
  function automatic requant_t requant(input logic signed [31:0] x,
                                       input int unsigned        shift,
                                       input int unsigned        w_o);
    requant_t           res;
    logic signed [31:0] r;
    r = (x + (32'sd1 <<< (shift - 1))) >>> shift;
    if (r > sat_max(w_o)) begin
      res.val = sat_max(w_o);
      res.sat = 1'b1;
    end else if (r < sat_min(w_o)) begin
      res.val = sat_min(w_o);
      res.sat = 1'b1;
    end else begin
      res.val = r;
      res.sat = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; the head entry is always visible on data_o.
module sync_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  // A push into a full FIFO is only taken when a pop frees the slot in the same cycle.
  always_comb begin
    full_o  = (cnt_q == CW'(DEPTH));
    empty_o = (cnt_q == '0);
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    data_o  = mem_q[rptr_q];
  end

  // Storage, pointers (wrap naturally at the power-of-2 depth) and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (do_pop) rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/fir_requant_decim.sv
// Decimate the filter output by D, round/saturate to W_O bits and queue for a valid/ready consumer.
module fir_requant_decim
  import dsp_pkg::*;
#(
  parameter int unsigned W_I   = 14,
  parameter int unsigned W_O   = 8,
  parameter int unsigned SHIFT = 6,
  parameter int unsigned D     = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic signed [W_I-1:0] x,
  input  logic                  x_valid,
  output logic signed [W_O-1:0] y,
  output logic                  y_valid,
  input  logic                  y_ready,
  output logic                  sat,
  output logic                  ovf,
  input  logic                  clr
);

  localparam int unsigned    PhW    = (D > 1) ? $clog2(D) : 1;
  localparam logic [PhW-1:0] PhLast = PhW'(D - 1);

  logic [PhW-1:0]        ph_q, ph_d;
  logic                  keep;
  requant_t              rq;
  logic signed [W_O-1:0] st_data_q, st_data_d;
  logic                  st_valid_q;
  logic                  sat_q, sat_d, ovf_q, ovf_d;
  logic                  push, pop, drop;
  logic                  fifo_full, fifo_empty;
  logic                  unused_rq_hi;

  // Phase tracking, requantisation of the current sample and the drop/flag decisions.
  always_comb begin
    keep = x_valid && (ph_q == '0);
    ph_d = ph_q;
    if (x_valid) ph_d = (ph_q == PhLast) ? '0 : ph_q + 1'b1;

    rq        = requant(32'(x), SHIFT, W_O);
    st_data_d = keep ? rq.val[W_O-1:0] : st_data_q;

    push = st_valid_q;
    pop  = y_valid && y_ready;
    // Drop only when no pop frees a slot this cycle.
    drop = push && fifo_full && !pop;

    // A new event wins over a simultaneous clear.
    sat_d = (keep && rq.sat) || (sat_q && !clr);
    ovf_d = drop || (ovf_q && !clr);
  end

  // Upper bits are always a sign extension of the clamped value.
  assign unused_rq_hi = ^rq.val[31:W_O];

  // Phase counter, stage register and sticky flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ph_q       <= '0;
      st_data_q  <= '0;
      st_valid_q <= 1'b0;
      sat_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      ph_q       <= ph_d;
      st_data_q  <= st_data_d;
      st_valid_q <= keep;
      sat_q      <= sat_d;
      ovf_q      <= ovf_d;
    end
  end

  sync_fifo #(
    .W    (W_O),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .rst_ni (rstn),
    .push_i (push && !drop),
    .data_i (st_data_q),
    .pop_i  (pop),
    .data_o (y),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign y_valid = !fifo_empty;
  assign sat     = sat_q;
  assign ovf     = ovf_q;

endmodule

// File: doc/fir_requant_decim.md
# fir_requant_decim

Downstream stage for the FIR filter output. Takes the full-precision signed filter result every valid cycle, keeps one sample in every `D`, rounds and saturates it to a narrow output width, and buffers it in a small FIFO. The FIFO drains over a valid/ready handshake towards the next consumer (DMA packer or serialiser). Overflow and saturation events are flagged for status readout.

## Interface
- `W_I`, default 14: input width, matching the filter output (8 + 3 + clog2(5)).
- `W_O`, default 8: output sample width; `W_O` < `W_I` − `SHIFT` is legal and saturates.
- `SHIFT`, default 6: right-shift (fractional bits dropped), at least 1.
- `D`, default 4: decimation factor, at least 1; `D` = 1 keeps every sample.
- `DEPTH`, default 4: FIFO entries, a power of 2, at least 2.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rstn`  in  1  reset; asynchronous, active-low.
- `x`  in  `W_I` signed  filter output sample.
- `x_valid`  in  1  `x` is a new sample this cycle.
- `y`  out  `W_O` signed  FIFO head sample.
- `y_valid`  out  1  FIFO not empty.
- `y_ready`  in  1  consumer accepts `y` this cycle.
- `sat`  out  1  sticky; a kept sample was clipped.
- `ovf`  out  1  sticky; a kept sample was dropped because the FIFO was full.
- `clr`  in  1  synchronous clear of `sat` and `ovf` only.

## Operation
- **Phase counter** `ph`, range 0..`D`−1.
  - Advances on every `x_valid` and wraps from `D`−1 to 0.
  - A sample is kept when `x_valid` is high and `ph` == 0, so the first valid sample after reset is kept.
- **Requantisation** of a kept sample, computed combinationally in `W_I`+1 bits:
  - r = (x + 2^(`SHIFT`−1)) >>> `SHIFT`, which rounds half toward +inf.
  - If r > 2^(`W_O`−1)−1, clamp to that value. If r < −2^(`W_O`−1), clamp to that value.
  - Set `sat` on any clamp.
- **Stage register**
  - Captures the requantised value and a valid bit on a keep cycle.
  - The valid bit clears on any cycle with no keep.
- **FIFO** (show-ahead):
  - A push occurs when the stage register is valid.
  - A pop occurs when `y_valid` && `y_ready`.
  - `y` always shows the head entry; it holds its previous contents when empty and is don't-care when `y_valid` = 0.
  - Full with a push and a pop in the same cycle: both happen and the occupancy stays the same.
  - Full with a push and no pop: the sample is dropped and `ovf` is set. Head and contents are unchanged.
  - Empty with a push: the pop cannot occur because `y_valid` = 0. The sample is written and `y_valid` rises next cycle.
- **Sticky flags**
  - `sat` and `ovf` set on the event and hold until `clr` or reset.
  - If `clr` and a new event occur in the same cycle, the set wins.
- **Reset mid-operation:** all state clears immediately, including `ph`, stage valid, FIFO pointers and count, and both flags. Any partially-collected decimation window is discarded.

## Timing
- **Reset values:** `y` = 0, `y_valid` = 0, `sat` = 0, `ovf` = 0; internally `ph` = 0.
- **Latency**
  - A kept sample presented before edge k is in the stage register after edge k.
  - It is in the FIFO, with `y_valid` = 1 (if the FIFO was empty), after edge k+1.
  - Total latency is 2 cycles.
- **Throughput:** one kept sample per `D` valid inputs. With `D` = 1 and `y_ready` held high, the block sustains 1 sample/cycle with no drops.
- **Handshake**
  - `y_valid` does not depend combinationally on `y_ready`.
  - `y` and `y_valid` stay stable until accepted.
- **Flag timing:** `sat` asserts one cycle after the keep edge, when the stage register loads. `ovf` asserts one edge after the dropped push.
- **Occupancy counter:** width clog2(`DEPTH`+1); read and write pointers wrap at `DEPTH`.

## Structure
- **Shared package** `dsp_pkg`:
  - function `requant(x, SHIFT, W_O)` returning the value and a sat bit;
  - localparams for the saturation limits, derived from `W_O`.
  - `fir_filter` and future stages reuse this package.
- **Sub-module** `sync_fifo` (parameters `W`, `DEPTH`): show-ahead, with full/empty outputs and push/pop inputs. The drop-on-full policy and the `ovf` flag live in the parent, not in the FIFO.
- **Top level** holds the phase counter, the requant stage register and the flags.

## Test plan
- **Decimation:** reset, `D`=4, `x_valid`=1, `x` = 64·n for n = 0..15, `y_ready`=1.
  - Required: `y` = 0, 4, 8, 12.
  - The first output has `y_valid` high 2 cycles after the n=0 edge.
- **Rounding**, `D`=1:
  - `x` = 95, 96, −32, −33 gives `y` = 1, 2, 0, −1.
  - `sat` stays 0 throughout.
- **Saturation**, `D`=1:
  - `x` = 8191 gives `y` = 127 and sets `sat`.
  - `x` = −8192 gives `y` = −128.
  - Pulsing `clr` with no further event drops `sat` to 0.
- **Backpressure and overflow:** `D`=1, `y_ready`=0, 6 valid samples 1..6 (each times 64).
  - Required: 4 stored, `ovf`=1.
  - Raising `y_ready` drains 1, 2, 3, 4, after which `y_valid`=0.
- **Full with simultaneous push and pop:** hold `y_ready`=1 at 1 sample/cycle with the FIFO full.
  - Required: no drop, `ovf` stays 0, order preserved.
- **Reset mid-window:** `D`=4, 2 valid samples, assert `rstn`=0 for 1 cycle, then release.
  - Required: all outputs at reset values.
  - The next valid sample is kept (`ph` restarted).
